// File: rtl/disp_ram_arbiter.sv
// Display RAM arbiter: fixed-latency video fetch with absolute priority,
// CPU reads/writes slotted into free cycles behind a req/ack handshake.
module disp_ram_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = 16
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_starve
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE,
        RD1,
        RD2,
        WR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_cpu_slot;
    logic              w_blocked;
    logic              w_ack_nxt;
    logic              w_rd_cap;
    logic [CNT_W-1:0]  w_wait_nxt;
    logic [CNT_W-1:0]  r_wait;
    logic [1:0]        r_vtag;
    logic [DATA_W-1:0] r_vid_data;
    logic              r_vid_valid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_ack;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_starve;

    assign w_cpu_slot = !vid_req && cpu_req && (r_state == IDLE);
    assign w_blocked  = vid_req && cpu_req && (r_state == IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_rd_cap    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cpu_slot)
                    w_state_nxt = cpu_we ? WR : RD1;
            end
            RD1: w_state_nxt = RD2;
            RD2: begin
                w_state_nxt = IDLE;
                w_ack_nxt   = 1'b1;
                w_rd_cap    = 1'b1;
            end
            WR: begin
                w_state_nxt = IDLE;
                w_ack_nxt   = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_wait_nxt = r_wait;
        if (w_cpu_slot)
            w_wait_nxt = '0;
        else if (w_blocked && r_wait != LIM)
            w_wait_nxt = r_wait + CNT_W'(1);
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_wait      <= '0;
            r_starve    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_starve  <= r_starve | (w_wait_nxt == LIM);
            r_cpu_ack <= w_ack_nxt;
            if (w_rd_cap)
                r_cpu_rdata <= ram_rdata;
        end
    end

    // Video owns the slot whenever it asks; the CPU FSM never gates it.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_we <= 1'b0;
            if (vid_req) begin
                r_ram_addr <= vid_addr;
            end else if (w_cpu_slot) begin
                r_ram_addr  <= cpu_addr;
                r_ram_we    <= cpu_we;
                r_ram_wdata <= cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_vtag      <= 2'b00;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            r_vtag      <= {r_vtag[0], vid_req};
            r_vid_valid <= r_vtag[1];
            if (r_vtag[1])
                r_vid_data <= ram_rdata;
        end
    end

    assign vid_data   = r_vid_data;
    assign vid_valid  = r_vid_valid;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ack    = r_cpu_ack;
    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;
    assign cpu_starve = r_starve;

endmodule

// File: tb/tb_disp_ram_arbiter.sv
// Bench for disp_ram_arbiter: RAM model, golden memory image and a
// due-cycle video scoreboard, driven by directed and random steps.
module tb_disp_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_req;
    logic [10:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        cpu_starve;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int we_cnt = 0;

    logic [7:0] mem [2048];
    logic [7:0] gm  [2048];

    typedef struct {
        int         due;
        logic [7:0] d;
    } vexp_t;
    vexp_t vq[$];

    disp_ram_arbiter #(
        .ADDR_W    (11),
        .DATA_W    (8),
        .STARVE_LIM(16)
    ) dut (
        .clk_pixel (clk),
        .reset_n   (reset_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .cpu_starve(cpu_starve)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each video request is due two edges later with the image contents
    // as they stood when the request was sampled.
    always @(posedge clk) begin
        cyc++;
        if (!reset_n)
            vq.delete();
        else if (vid_req)
            vq.push_back('{cyc + 2, gm[vid_addr]});
    end

    always @(negedge clk) begin
        if (ram_we === 1'b1)
            we_cnt++;
        if (!reset_n) begin
            vq.delete();
            chk("vid_valid_rst", {31'd0, vid_valid}, 0);
        end else if (vq.size() > 0 && vq[0].due == cyc) begin
            chk("vid_valid", {31'd0, vid_valid}, 1);
            chk("vid_data", {24'd0, vid_data}, {24'd0, vq[0].d});
            void'(vq.pop_front());
        end else begin
            chk("vid_idle", {31'd0, vid_valid}, 0);
        end
    end

    task automatic cpu_xfer(input logic we, input logic [10:0] addr,
                            input logic [7:0] wd, input int exp_lat);
        int  w0;
        int  n;
        bit  got;
        w0  = we_cnt;
        got = 1'b0;
        n   = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (cpu_ack === 1'b1)
                got = 1'b1;
        end
        cpu_req = 1'b0;
        chk("cpu_ack_seen", {31'd0, got}, 1);
        if (exp_lat > 0)
            chk("cpu_latency", n, exp_lat);
        if (!we)
            chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, gm[addr]});
        else
            gm[addr] = wd;
        @(negedge clk);
        chk("cpu_ack_pulse", {31'd0, cpu_ack}, 0);
        chk("ram_we_count", we_cnt - w0, {31'd0, we});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vid_data"}, {24'd0, vid_data}, 0);
        chk({tag, "_vid_valid"}, {31'd0, vid_valid}, 0);
        chk({tag, "_cpu_rdata"}, {24'd0, cpu_rdata}, 0);
        chk({tag, "_cpu_ack"}, {31'd0, cpu_ack}, 0);
        chk({tag, "_ram_addr"}, {21'd0, ram_addr}, 0);
        chk({tag, "_ram_we"}, {31'd0, ram_we}, 0);
        chk({tag, "_ram_wdata"}, {24'd0, ram_wdata}, 0);
        chk({tag, "_starve"}, {31'd0, cpu_starve}, 0);
    endtask

    initial begin
        logic [10:0] va;
        logic [10:0] vb;
        logic [10:0] ra;
        int          w0;
        int          n;
        bit          got;

        reset_n   = 1'b0;
        vid_req   = 1'b0;
        vid_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 8'(i + 1);
            gm[i]  = 8'(i + 1);
        end
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // video sweep, one fetch every 8 cycles
        w0 = we_cnt;
        for (int a = 0; a < 64; a++) begin
            vid_req  = 1'b1;
            vid_addr = 11'(a);
            @(negedge clk);
            vid_req = 1'b0;
            repeat (7) @(negedge clk);
        end
        chk("sweep_no_write", we_cnt - w0, 0);

        // corner address write then read
        cpu_xfer(1'b1, 11'h7FF, 8'hA5, 2);
        cpu_xfer(1'b0, 11'h7FF, 8'h00, 3);

        // random CPU traffic without video
        for (int i = 0; i < 24; i++)
            cpu_xfer(1'($urandom), 11'($urandom), 8'($urandom),
                     -1);
        for (int i = 0; i < 8; i++) begin
            ra = 11'($urandom);
            cpu_xfer(1'b1, ra, 8'($urandom), 2);
            cpu_xfer(1'b0, ra, 8'h00, 3);
        end

        // write then immediate video read of the same address
        cpu_xfer(1'b1, 11'h123, 8'h5A, 2);
        vid_req  = 1'b1;
        vid_addr = 11'h123;
        @(negedge clk);
        vid_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("wr_then_vid", {24'd0, vid_data}, 32'h5A);
        @(negedge clk);

        // video and CPU together, video also on the next edge
        va = 11'h200 | 11'($urandom_range(0, 255));
        vb = 11'h400 | 11'($urandom_range(0, 255));
        vid_req  = 1'b1;
        vid_addr = va;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 11'h010;
        @(negedge clk);
        vid_addr = vb;
        chk("sim_ack_k1", {31'd0, cpu_ack}, 0);
        @(negedge clk);
        vid_req = 1'b0;
        chk("sim_ram_addr_vb", {21'd0, ram_addr}, {21'd0, vb});
        @(negedge clk);
        chk("sim_ram_addr_cpu", {21'd0, ram_addr}, 32'h010);
        chk("sim_ack_k3", {31'd0, cpu_ack}, 0);
        @(negedge clk);
        chk("sim_ack_k4", {31'd0, cpu_ack}, 0);
        @(negedge clk);
        chk("sim_ack_k5", {31'd0, cpu_ack}, 1);
        chk("sim_rdata", {24'd0, cpu_rdata}, {24'd0, gm[11'h010]});
        cpu_req = 1'b0;
        @(negedge clk);
        chk("sim_ack_end", {31'd0, cpu_ack}, 0);

        // CPU read in RD1 while a video fetch arrives
        ra = 11'h050;
        va = 11'h060;
        cpu_xfer(1'b1, ra, 8'h3C, 2);
        cpu_xfer(1'b1, va, 8'hC3, 2);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = ra;
        @(negedge clk);
        vid_req  = 1'b1;
        vid_addr = va;
        @(negedge clk);
        vid_req = 1'b0;
        @(negedge clk);
        chk("rd1_ack", {31'd0, cpu_ack}, 1);
        chk("rd1_rdata", {24'd0, cpu_rdata}, 32'h3C);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd1_vid_valid", {31'd0, vid_valid}, 1);
        chk("rd1_vid_data", {24'd0, vid_data}, 32'hC3);

        // starvation: video held for 20 edges against a pending read
        chk("starve_before", {31'd0, cpu_starve}, 0);
        ra       = 11'($urandom);
        vid_req  = 1'b1;
        vid_addr = 11'($urandom);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = ra;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            vid_addr = 11'($urandom);
            chk("starve_flag", {31'd0, cpu_starve}, {31'd0, k >= 16});
            chk("starve_no_ack", {31'd0, cpu_ack}, 0);
        end
        @(negedge clk);
        vid_req = 1'b0;
        chk("starve_k20", {31'd0, cpu_starve}, 1);
        got = 1'b0;
        n   = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (cpu_ack === 1'b1)
                got = 1'b1;
        end
        cpu_req = 1'b0;
        chk("starve_served", {31'd0, got}, 1);
        chk("starve_latency", n, 3);
        chk("starve_rdata", {24'd0, cpu_rdata}, {24'd0, gm[ra]});
        @(negedge clk);
        chk("starve_sticky", {31'd0, cpu_starve}, 1);

        // random video traffic mixed with CPU reads
        for (int i = 0; i < 16; i++) begin
            ra       = 11'($urandom);
            cpu_req  = 1'b1;
            cpu_we   = 1'b0;
            cpu_addr = ra;
            got      = 1'b0;
            n        = 0;
            while (!got && n < 40) begin
                vid_req  = 1'($urandom);
                vid_addr = 11'($urandom);
                @(negedge clk);
                n++;
                if (cpu_ack === 1'b1)
                    got = 1'b1;
            end
            vid_req = 1'b0;
            cpu_req = 1'b0;
            chk("mix_served", {31'd0, got}, 1);
            chk("mix_rdata", {24'd0, cpu_rdata}, {24'd0, gm[ra]});
        end
        repeat (4) @(negedge clk);

        // reset during a CPU read in RD1
        ra       = 11'h100 | 11'($urandom_range(1, 255));
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = ra;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_no_ack", {31'd0, cpu_ack}, 0);
        end
        cpu_xfer(1'b0, ra, 8'h00, 3);
        chk("post_rst_starve", {31'd0, cpu_starve}, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
